// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_queue
// Brief   : Fetch stage: owns the PC, queues fetched instructions for decode,
//           and flushes on redirect. Optional counters: IF_FETCH_PERF_EN.
// Rev     : 1.0  initial release
// ============================================================================
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fetch_addr,
    output logic        pc_changed,
    input  logic [31:0] mb_inst,
    input  logic        mb_inst_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_drop_cnt
`endif
);

    localparam int unsigned   c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_fetch_addr;
    logic          r_discard;
    logic          r_pc_changed;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_accept;

    // Equal indices with differing wrap bits means the FIFO is full.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop    = !w_empty && id_ready && !redirect;
    assign w_accept = mb_inst_en && !redirect && !r_discard && (!w_full || w_pop);

    assign fetch_addr = r_fetch_addr;
    assign pc_changed = r_pc_changed;
    assign id_valid   = !w_empty;
    assign id_inst    = w_empty ? 32'h0 : r_mem_inst[r_rd_ptr[c_AW-1:0]];
    assign id_pc      = w_empty ? 32'h0 : r_mem_pc[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_inst[r_wr_ptr[c_AW-1:0]] <= mb_inst;
            r_mem_pc[r_wr_ptr[c_AW-1:0]]   <= r_fetch_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fetch_addr <= RESET_PC;
            r_discard    <= 1'b0;
            r_pc_changed <= 1'b0;
        end else begin
            r_pc_changed <= redirect;
            if (redirect) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_fetch_addr <= redirect_pc;
                // Without a coincident strobe, the buffer's in-flight word mixes old and new bytes.
                r_discard    <= !mb_inst_en;
            end else begin
                if (r_discard && mb_inst_en) begin
                    r_discard <= 1'b0;
                end
                if (w_accept) begin
                    r_wr_ptr     <= r_wr_ptr + c_PTR_ONE;
                    r_fetch_addr <= r_fetch_addr + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
            end
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [15:0] r_perf_fetch;
    logic [15:0] r_perf_drop;
    logic        w_drop;

    assign w_drop         = mb_inst_en && !w_accept;
    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_drop_cnt  = r_perf_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= 16'h0;
            r_perf_drop  <= 16'h0;
        end else begin
            if (w_accept && (r_perf_fetch != 16'hFFFF)) begin
                r_perf_fetch <= r_perf_fetch + 16'd1;
            end
            if (w_drop && (r_perf_drop != 16'hFFFF)) begin
                r_perf_drop <= r_perf_drop + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch_queue
// Brief   : Self-checking bench for if_fetch_queue against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        pc_changed;
    logic [31:0] mb_inst;
    logic        mb_inst_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
`ifdef IF_FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_drop_cnt;
`endif

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_addr  (fetch_addr),
        .pc_changed  (pc_changed),
        .mb_inst     (mb_inst),
        .mb_inst_en  (mb_inst_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    // Reference model: the queue holds exactly what decode should see, in order.
    ent_t        mq[$];
    logic [31:0] m_addr;
    bit          m_discard;
    bit          m_pcchg;
    int          m_fetch;
    int          m_drop;

    int checks = 0;
    int fails  = 0;

    function automatic logic [31:0] e_pc();
        return (mq.size() > 0) ? mq[0].pc : 32'h0;
    endfunction

    function automatic logic [31:0] e_inst();
        return (mq.size() > 0) ? mq[0].inst : 32'h0;
    endfunction

    // Drives one cycle of inputs, advances the model, samples 1 ns after the edge.
    task automatic step(input bit r, input bit en, input logic [31:0] inst,
                        input bit rd, input logic [31:0] rpc, input bit rdy);
        bit pop;
        bit room;
        rst = r; mb_inst_en = en; mb_inst = inst;
        redirect = rd; redirect_pc = rpc; id_ready = rdy;
        pop  = (mq.size() > 0) && rdy;
        room = (mq.size() < DEPTH) || pop;
        if (r) begin
            mq.delete();
            m_addr = RESET_PC; m_discard = 0; m_pcchg = 0; m_fetch = 0; m_drop = 0;
        end else if (rd) begin
            mq.delete();
            m_addr = rpc; m_pcchg = 1; m_discard = !en;
            if (en && m_drop < 65535) m_drop++;
        end else begin
            m_pcchg = 0;
            if (pop) void'(mq.pop_front());
            if (en) begin
                if (m_discard) begin
                    m_discard = 0;
                    if (m_drop < 65535) m_drop++;
                end else if (room) begin
                    mq.push_back(ent_t'{inst, m_addr});
                    m_addr = m_addr + 32'd4;
                    if (m_fetch < 65535) m_fetch++;
                end else begin
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic strobe5(input logic [31:0] inst, input bit rdy);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 32'h0, rdy);
        step(0, 1, inst, 0, 32'h0, rdy);
    endtask

    task automatic test_reset();
        step(1, 1, 32'hDEAD_BEEF, 0, 32'h0, 1);
        step(1, 0, 32'h0, 0, 32'h0, 0);
        checks++; if (fetch_addr !== RESET_PC) begin fails++; $display("FAIL reset_fetch_addr got=%h exp=%h", fetch_addr, RESET_PC); end
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        checks++; if (id_inst !== 32'h0 || id_pc !== 32'h0) begin fails++; $display("FAIL reset_head got=%h/%h exp=0/0", id_inst, id_pc); end
        checks++; if (pc_changed !== 1'b0) begin fails++; $display("FAIL reset_pc_changed got=%b exp=0", pc_changed); end
    endtask

    task automatic test_sequential();
        step(1, 0, 32'h0, 0, 32'h0, 1);
        for (int k = 0; k < 4; k++) begin
            strobe5(32'h0000_0013, 1);
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== 32'h13)
                begin fails++; $display("FAIL seq_head[%0d] got=%b/%h/%h exp=1/%h/00000013", k, id_valid, id_pc, id_inst, 32'(4 * k)); end
            checks++; if (fetch_addr !== 32'(4 * (k + 1)))
                begin fails++; $display("FAIL seq_fetch_addr[%0d] got=%h exp=%h", k, fetch_addr, 32'(4 * (k + 1))); end
        end
    endtask

    task automatic test_full();
        step(1, 0, 32'h0, 0, 32'h0, 0);
        for (int k = 0; k < 6; k++) strobe5(32'h1000 + 32'(k), 0);
        checks++; if (fetch_addr !== 32'd16) begin fails++; $display("FAIL full_hold_addr got=%h exp=00000010", fetch_addr); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== 32'h1000 + 32'(k))
                begin fails++; $display("FAIL full_drain[%0d] got=%b/%h/%h exp=1/%h/%h", k, id_valid, id_pc, id_inst, 32'(4 * k), 32'h1000 + 32'(k)); end
            step(0, 0, 32'h0, 0, 32'h0, 1);
        end
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL full_empty got=%b exp=0", id_valid); end
        strobe5(32'h2000, 0);
        checks++; if (id_pc !== 32'd16 || id_inst !== 32'h2000) begin fails++; $display("FAIL full_resume got=%h/%h exp=00000010/00002000", id_pc, id_inst); end
    endtask

    task automatic test_redirect_mid();
        step(1, 0, 32'h0, 0, 32'h0, 0);
        strobe5(32'hA0, 0);
        strobe5(32'hA1, 0);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 1, 32'h100, 1);
        checks++; if (id_valid !== 1'b0 || pc_changed !== 1'b1 || fetch_addr !== 32'h100)
            begin fails++; $display("FAIL redir_mid got=v%b pcc%b a%h exp=v0 pcc1 a00000100", id_valid, pc_changed, fetch_addr); end
        step(0, 0, 32'h0, 0, 32'h0, 1);
        checks++; if (pc_changed !== 1'b0) begin fails++; $display("FAIL redir_pulse got=%b exp=0", pc_changed); end
        strobe5(32'hBAD, 1);
        checks++; if (id_valid !== 1'b0 || fetch_addr !== 32'h100)
            begin fails++; $display("FAIL redir_discard got=v%b a%h exp=v0 a00000100", id_valid, fetch_addr); end
        strobe5(32'hB0, 0);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'hB0 || fetch_addr !== 32'h104)
            begin fails++; $display("FAIL redir_next got=v%b %h/%h a%h exp=v1 00000100/000000b0 a00000104", id_valid, id_pc, id_inst, fetch_addr); end
    endtask

    task automatic test_redirect_coincident();
        step(1, 0, 32'h0, 0, 32'h0, 0);
        strobe5(32'hC0, 0);
        step(0, 1, 32'hBAD, 1, 32'h200, 0);
        checks++; if (id_valid !== 1'b0 || fetch_addr !== 32'h200 || pc_changed !== 1'b1)
            begin fails++; $display("FAIL coinc_redir got=v%b a%h pcc%b exp=v0 a00000200 pcc1", id_valid, fetch_addr, pc_changed); end
        strobe5(32'hC1, 0);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== 32'hC1)
            begin fails++; $display("FAIL coinc_next got=v%b %h/%h exp=v1 00000200/000000c1", id_valid, id_pc, id_inst); end
    endtask

    task automatic test_full_push_pop();
        int cnt;
        step(1, 0, 32'h0, 0, 32'h0, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 32'hD0 + 32'(k), 0, 32'h0, 0);
        step(0, 1, 32'hD4, 0, 32'h0, 1);
        checks++; if (id_pc !== 32'd4 || fetch_addr !== 32'd20)
            begin fails++; $display("FAIL pp_step got=%h a%h exp=00000004 a00000014", id_pc, fetch_addr); end
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (id_valid === 1'b1) begin
                cnt++;
                checks++; if (id_pc !== 32'(4 * cnt) || id_inst !== 32'hD0 + 32'(cnt))
                    begin fails++; $display("FAIL pp_entry[%0d] got=%h/%h exp=%h/%h", cnt, id_pc, id_inst, 32'(4 * cnt), 32'hD0 + 32'(cnt)); end
            end
            step(0, 0, 32'h0, 0, 32'h0, 1);
        end
        checks++; if (cnt != 4) begin fails++; $display("FAIL pp_count got=%0d exp=4", cnt); end
    endtask

    task automatic test_wrap();
        step(0, 1, 32'h0, 1, 32'hFFFF_FFFC, 0);
        step(0, 1, 32'hE0, 0, 32'h0, 0);
        checks++; if (fetch_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC)
            begin fails++; $display("FAIL wrap got=a%h pc%h exp=a00000000 pcfffffffc", fetch_addr, id_pc); end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int i = 0; i < 1500; i++) begin
            rpc = $urandom();
            rpc[1:0] = 2'b00;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), $urandom(),
                 ($urandom_range(0, 29) == 0), rpc, ($urandom_range(0, 2) != 0));
            checks++; if (id_valid !== (mq.size() > 0) || id_pc !== e_pc() || id_inst !== e_inst())
                begin fails++; $display("FAIL rnd_head[%0d] got=v%b %h/%h exp=v%b %h/%h", i, id_valid, id_pc, id_inst, (mq.size() > 0), e_pc(), e_inst()); end
            checks++; if (fetch_addr !== m_addr || pc_changed !== m_pcchg)
                begin fails++; $display("FAIL rnd_addr[%0d] got=a%h pcc%b exp=a%h pcc%b", i, fetch_addr, pc_changed, m_addr, m_pcchg); end
`ifdef IF_FETCH_PERF_EN
            checks++; if (perf_fetch_cnt !== 16'(m_fetch) || perf_drop_cnt !== 16'(m_drop))
                begin fails++; $display("FAIL rnd_perf[%0d] got=%0d/%0d exp=%0d/%0d", i, perf_fetch_cnt, perf_drop_cnt, m_fetch, m_drop); end
`endif
        end
    endtask

`ifdef IF_FETCH_PERF_EN
    task automatic test_perf_saturate();
        step(1, 0, 32'h0, 0, 32'h0, 1);
        step(0, 1, 32'h1, 0, 32'h0, 1);
        checks++; if (perf_fetch_cnt !== 16'd1) begin fails++; $display("FAIL perf_inc got=%0d exp=1", perf_fetch_cnt); end
        for (int i = 0; i < 65540; i++) step(0, 1, 32'h1, 0, 32'h0, 1);
        checks++; if (perf_fetch_cnt !== 16'hFFFF) begin fails++; $display("FAIL perf_sat got=%h exp=ffff", perf_fetch_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_full();
        test_redirect_mid();
        test_redirect_coincident();
        test_full_push_pop();
        test_wrap();
        test_random();
`ifdef IF_FETCH_PERF_EN
        test_perf_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
